// File: rtl/fft_mac_sequencer.sv
// Frame sequencer for the four-MAC FFT butterfly stage: accept, issue four phases, capture, hold.
// Define FFT_MAC_SEQ_PERF_EN to build the completed-frame counter on frames_done.
module fft_mac_sequencer #(
  parameter int MAC_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2047:0] in_frame,
  output logic [2047:0] mac_frame,
  output logic [1:0]    mac_sel,
  output logic          mac_issue,
  input  logic [511:0]  mac_res,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2047:0] out_frame,
  output logic          busy,
  output logic [15:0]   frames_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;

  localparam logic [2:0] DRAIN_LAST = 3'(MAC_LAT - 1);

  state_t     state, state_next;
  logic [2:0] cnt, cnt_next;
  logic       accept;
  logic       out_fire;
  logic       cap_issue;
  logic [1:0] cap_sel;

  assign accept   = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    in_ready   = 1'b0;
    mac_issue  = 1'b0;
    mac_sel    = 2'd0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_next = ISSUE;
          cnt_next   = '0;
        end
      end
      ISSUE: begin
        mac_issue = 1'b1;
        mac_sel   = cnt[1:0];
        cnt_next  = cnt + 3'd1;
        if (cnt == 3'd3) begin
          cnt_next   = '0;
          state_next = (MAC_LAT > 0) ? DRAIN : HOLD;
        end
      end
      DRAIN: begin
        cnt_next = cnt + 3'd1;
        if (cnt == DRAIN_LAST) begin
          cnt_next   = '0;
          state_next = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)       mac_frame <= '0;
    else if (accept) mac_frame <= in_frame;
  end

  // Phase tag travels alongside the MAC array so captures line up with its latency.
  generate
    if (MAC_LAT == 0) begin : g_nodly
      assign cap_issue = mac_issue;
      assign cap_sel   = mac_sel;
    end else begin : g_dly
      logic [2:0] dly [MAC_LAT];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < MAC_LAT; i++) dly[i] <= '0;
        end else begin
          dly[0] <= {mac_issue, mac_sel};
          for (int i = 1; i < MAC_LAT; i++) dly[i] <= dly[i-1];
        end
      end
      assign {cap_issue, cap_sel} = dly[MAC_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      out_frame <= '0;
    end else if (cap_issue) begin
      for (int k = 0; k < 4; k++) begin
        out_frame[64*(8*k + int'(cap_sel)) +: 64]     <= mac_res[128*k +: 64];
        out_frame[64*(8*k + 4 + int'(cap_sel)) +: 64] <= mac_res[128*k + 64 +: 64];
      end
    end
  end

`ifdef FFT_MAC_SEQ_PERF_EN
  logic [15:0] frames_done_q;

  always_ff @(posedge clk) begin
    if (reset)         frames_done_q <= '0;
    else if (out_fire) frames_done_q <= frames_done_q + 16'd1;
  end

  assign frames_done = frames_done_q;
`else
  assign frames_done = 16'h0000;
`endif

endmodule

// File: tb/tb_fft_mac_sequencer.sv
// Directed bench for fft_mac_sequencer: three instances (MAC_LAT 1, 0, 4) with echoing MAC models.
module tb_fft_mac_sequencer;

  logic          clk = 1'b0;
  logic          reset;
  logic [2047:0] in_frame;

  logic          in_valid1, in_ready1, mac_issue1, out_valid1, out_ready1, busy1;
  logic [2047:0] mac_frame1, out_frame1;
  logic [1:0]    mac_sel1;
  logic [511:0]  mac_res1;
  logic [15:0]   frames_done1;

  logic          in_valid0, in_ready0, mac_issue0, out_valid0, out_ready0, busy0;
  logic [2047:0] mac_frame0, out_frame0;
  logic [1:0]    mac_sel0;
  logic [511:0]  mac_res0;
  logic [15:0]   frames_done0;

  logic          in_valid4, in_ready4, mac_issue4, out_valid4, out_ready4, busy4;
  logic [2047:0] mac_frame4, out_frame4;
  logic [1:0]    mac_sel4;
  logic [511:0]  mac_res4;
  logic [15:0]   frames_done4;
  logic [511:0]  res4_pipe [4];

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fft_mac_sequencer #(.MAC_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1), .in_frame(in_frame),
    .mac_frame(mac_frame1), .mac_sel(mac_sel1), .mac_issue(mac_issue1), .mac_res(mac_res1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_frame(out_frame1), .busy(busy1),
    .frames_done(frames_done1)
  );

  fft_mac_sequencer #(.MAC_LAT(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0), .in_frame(in_frame),
    .mac_frame(mac_frame0), .mac_sel(mac_sel0), .mac_issue(mac_issue0), .mac_res(mac_res0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_frame(out_frame0), .busy(busy0),
    .frames_done(frames_done0)
  );

  fft_mac_sequencer #(.MAC_LAT(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4), .in_frame(in_frame),
    .mac_frame(mac_frame4), .mac_sel(mac_sel4), .mac_issue(mac_issue4), .mac_res(mac_res4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_frame(out_frame4), .busy(busy4),
    .frames_done(frames_done4)
  );

  // MAC model: each MAC echoes its two selected input words.
  function automatic logic [511:0] echo(input logic [2047:0] f, input logic [1:0] s);
    logic [511:0] r;
    for (int k = 0; k < 4; k++) begin
      r[128*k +: 64]      = f[64*(8*k + int'(s)) +: 64];
      r[128*k + 64 +: 64] = f[64*(8*k + 4 + int'(s)) +: 64];
    end
    return r;
  endfunction

  assign mac_res0 = echo(mac_frame0, mac_sel0);

  always @(posedge clk) mac_res1 <= echo(mac_frame1, mac_sel1);

  always @(posedge clk) begin
    res4_pipe[0] <= echo(mac_frame4, mac_sel4);
    for (int i = 1; i < 4; i++) res4_pipe[i] <= res4_pipe[i-1];
  end
  assign mac_res4 = res4_pipe[3];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic random_frame(output logic [2047:0] f);
    for (int i = 0; i < 64; i++) f[32*i +: 32] = $urandom;
  endtask

  // Accept one frame on the MAC_LAT=1 instance and return latency and output frame, ending in IDLE.
  task automatic send_frame1(input logic [2047:0] f, output int lat, output logic [2047:0] got);
    lat = -1;
    got = '0;
    in_frame   = f;
    in_valid1  = 1'b1;
    out_ready1 = 1'b1;
    tick;
    in_valid1 = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (out_valid1) begin
        lat = n;
        got = out_frame1;
        break;
      end
      tick;
    end
    tick;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    in_frame = '0;
    {in_valid1, in_valid0, in_valid4} = 3'b000;
    {out_ready1, out_ready0, out_ready4} = 3'b000;
    repeat (3) tick;
    tests_run++;
    if ({in_ready1, out_valid1, busy1, mac_issue1, mac_sel1} !== 6'b100000) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: got %b expected 100000",
               {in_ready1, out_valid1, busy1, mac_issue1, mac_sel1});
    end
    tests_run++;
    if (mac_frame1 !== '0 || out_frame1 !== '0 || frames_done1 !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: frames_done %h, frames nonzero=%b expected zero",
               frames_done1, (mac_frame1 != '0) || (out_frame1 != '0));
    end
    tests_run++;
    if ({in_ready0, out_valid0, in_ready4, out_valid4} !== 4'b1010 || out_frame0 !== '0 || out_frame4 !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_lat0_lat4: got ready/valid %b expected 1010",
               {in_ready0, out_valid0, in_ready4, out_valid4});
    end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    logic [2047:0] f, got;
    logic [7:0]    sel_seq;
    logic [3:0]    iss_seq;
    int            first;
    random_frame(f);
    first = -1;
    got = '0;
    sel_seq = '0;
    iss_seq = '0;
    in_frame   = f;
    in_valid1  = 1'b1;
    out_ready1 = 1'b1;
    tick;
    in_valid1 = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (n <= 4) begin
        sel_seq[2*(n-1) +: 2] = mac_sel1;
        iss_seq[n-1]          = mac_issue1;
      end
      if (out_valid1) begin
        first = n;
        got   = out_frame1;
        break;
      end
      tick;
    end
    tests_run++;
    if (first !== 6) begin
      tests_failed++;
      $display("[TB] FAIL basic_latency: out_valid at T+%0d expected T+6", first);
    end
    tests_run++;
    if (sel_seq !== 8'b11_10_01_00 || iss_seq !== 4'b1111) begin
      tests_failed++;
      $display("[TB] FAIL basic_sel_seq: sel %b issue %b expected 11100100 / 1111", sel_seq, iss_seq);
    end
    tests_run++;
    if (got !== f) begin
      tests_failed++;
      $display("[TB] FAIL basic_frame: word0 %h word31 %h expected %h %h",
               got[63:0], got[2047:1984], f[63:0], f[2047:1984]);
    end
    tick;
    tests_run++;
    if (in_ready1 !== 1'b1 || out_frame1 !== f || mac_frame1 !== f) begin
      tests_failed++;
      $display("[TB] FAIL basic_after: in_ready %b, frames held %b expected 1 / 1",
               in_ready1, (out_frame1 === f) && (mac_frame1 === f));
    end
  endtask

  task automatic test_latency_builds;
    logic [2047:0] f, got0, got4;
    int            first0, first4;
    for (int i = 0; i < 32; i++) f[64*i +: 64] = 64'h3F800000_00000000;
    first0 = -1;
    first4 = -1;
    got0 = '0;
    got4 = '0;
    in_frame = f;
    {in_valid0, in_valid4, out_ready0, out_ready4} = 4'b1111;
    tick;
    {in_valid0, in_valid4} = 2'b00;
    for (int n = 1; n <= 20; n++) begin
      if (out_valid0 && first0 < 0) begin
        first0 = n;
        got0   = out_frame0;
      end
      if (out_valid4 && first4 < 0) begin
        first4 = n;
        got4   = out_frame4;
      end
      if (first0 >= 0 && first4 >= 0) break;
      tick;
    end
    tick;
    tests_run++;
    if (first0 !== 5) begin
      tests_failed++;
      $display("[TB] FAIL lat0_timing: out_valid at T+%0d expected T+5", first0);
    end
    tests_run++;
    if (first4 !== 9) begin
      tests_failed++;
      $display("[TB] FAIL lat4_timing: out_valid at T+%0d expected T+9", first4);
    end
    tests_run++;
    if (got0 !== f) begin
      tests_failed++;
      $display("[TB] FAIL lat0_frame: word0 %h word31 %h expected 3f80000000000000",
               got0[63:0], got0[2047:1984]);
    end
    tests_run++;
    if (got4 !== f) begin
      tests_failed++;
      $display("[TB] FAIL lat4_frame: word0 %h word31 %h expected 3f80000000000000",
               got4[63:0], got4[2047:1984]);
    end
  endtask

  task automatic test_hold_stall;
    logic [2047:0] a, b;
    int            seen, bad_valid, bad_frame, bad_ready, bad_mac;
    random_frame(a);
    random_frame(b);
    seen = 0;
    bad_valid = 0;
    bad_frame = 0;
    bad_ready = 0;
    bad_mac   = 0;
    in_frame   = a;
    in_valid1  = 1'b1;
    out_ready1 = 1'b0;
    tick;
    in_valid1 = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (out_valid1) begin
        seen = 1;
        break;
      end
      tick;
    end
    tests_run++;
    if (seen !== 1) begin
      tests_failed++;
      $display("[TB] FAIL stall_reach_hold: out_valid seen %0d expected 1", seen);
    end
    in_frame  = b;
    in_valid1 = 1'b1;
    for (int n = 0; n < 10; n++) begin
      if (out_valid1 !== 1'b1) bad_valid++;
      if (out_frame1 !== a)    bad_frame++;
      if (in_ready1 !== 1'b0)  bad_ready++;
      if (mac_frame1 !== a)    bad_mac++;
      tick;
    end
    tests_run++;
    if (bad_valid !== 0 || bad_frame !== 0) begin
      tests_failed++;
      $display("[TB] FAIL stall_output: %0d valid drops, %0d frame changes expected 0 / 0", bad_valid, bad_frame);
    end
    tests_run++;
    if (bad_ready !== 0 || bad_mac !== 0) begin
      tests_failed++;
      $display("[TB] FAIL stall_input_ignored: %0d ready cycles, %0d mac_frame changes expected 0 / 0",
               bad_ready, bad_mac);
    end
    out_ready1 = 1'b1;
    tick;
    tests_run++;
    if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || out_frame1 !== a) begin
      tests_failed++;
      $display("[TB] FAIL stall_release: in_ready %b out_valid %b expected 1 / 0", in_ready1, out_valid1);
    end
    tick;
    in_valid1 = 1'b0;
    tests_run++;
    if (mac_frame1 !== b) begin
      tests_failed++;
      $display("[TB] FAIL stall_next_accept: mac_frame word0 %h expected %h", mac_frame1[63:0], b[63:0]);
    end
    seen = 0;
    for (int n = 2; n <= 20; n++) begin
      if (out_valid1) begin
        seen = 1;
        break;
      end
      tick;
    end
    tests_run++;
    if (seen !== 1 || out_frame1 !== b) begin
      tests_failed++;
      $display("[TB] FAIL stall_next_frame: seen %0d word0 %h expected 1 / %h", seen, out_frame1[63:0], b[63:0]);
    end
    tick;
  endtask

  task automatic test_reset_mid_issue;
    logic [2047:0] c, d, got;
    int            lat;
    random_frame(c);
    random_frame(d);
    in_frame   = c;
    in_valid1  = 1'b1;
    out_ready1 = 1'b1;
    tick;
    in_valid1 = 1'b0;
    tick;
    tick;
    tests_run++;
    if (mac_issue1 !== 1'b1 || mac_sel1 !== 2'd2) begin
      tests_failed++;
      $display("[TB] FAIL midreset_pre: issue %b sel %0d expected 1 / 2", mac_issue1, mac_sel1);
    end
    reset = 1'b1;
    tick;
    tests_run++;
    if ({in_ready1, out_valid1, mac_issue1, busy1} !== 4'b1000 || out_frame1 !== '0 || mac_frame1 !== '0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_state: ready/valid/issue/busy %b expected 1000, out_frame zero %b expected 1",
               {in_ready1, out_valid1, mac_issue1, busy1}, out_frame1 === '0);
    end
    reset = 1'b0;
    tick;
    send_frame1(d, lat, got);
    tests_run++;
    if (lat !== 6 || got !== d) begin
      tests_failed++;
      $display("[TB] FAIL midreset_recover: latency %0d word0 %h expected 6 / %h", lat, got[63:0], d[63:0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [2047:0] e;
    int            acc [3];
    int            nacc, cyc, idle;
    logic [15:0]   exp_done;
`ifdef FFT_MAC_SEQ_PERF_EN
    exp_done = 16'd3;
`else
    exp_done = 16'd0;
`endif
    random_frame(e);
    for (int i = 0; i < 3; i++) acc[i] = -100;
    nacc = 0;
    cyc  = 0;
    idle = 0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tick;
    in_frame   = e;
    in_valid1  = 1'b1;
    out_ready1 = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if (in_ready1) begin
        acc[nacc] = cyc;
        nacc++;
      end
      tick;
      cyc++;
      if (nacc == 3) break;
    end
    in_valid1 = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (!busy1) begin
        idle = 1;
        break;
      end
      tick;
    end
    tests_run++;
    if (nacc !== 3 || acc[1] - acc[0] !== 7 || acc[2] - acc[1] !== 7) begin
      tests_failed++;
      $display("[TB] FAIL b2b_period: %0d accepts at %0d %0d %0d expected 3 at spacing 7",
               nacc, acc[0], acc[1], acc[2]);
    end
    tests_run++;
    if (idle !== 1 || frames_done1 !== exp_done) begin
      tests_failed++;
      $display("[TB] FAIL b2b_count: idle %0d frames_done %0d expected 1 / %0d", idle, frames_done1, exp_done);
    end
    tests_run++;
    if (out_frame1 !== e) begin
      tests_failed++;
      $display("[TB] FAIL b2b_frame: word0 %h expected %h", out_frame1[63:0], e[63:0]);
    end
  endtask

  task automatic test_counter_wrap;
    logic [2047:0] f, got;
    int            lat;
    random_frame(f);
`ifdef FFT_MAC_SEQ_PERF_EN
    force dut1.frames_done_q = 16'hFFFF;
    tick;
    release dut1.frames_done_q;
    tests_run++;
    if (frames_done1 !== 16'hFFFF) begin
      tests_failed++;
      $display("[TB] FAIL wrap_preload: frames_done %h expected ffff", frames_done1);
    end
`endif
    send_frame1(f, lat, got);
    tests_run++;
    if (frames_done1 !== 16'h0000 || lat !== 6) begin
      tests_failed++;
      $display("[TB] FAIL wrap_result: frames_done %h latency %0d expected 0000 / 6", frames_done1, lat);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset;
    test_basic;
    test_latency_builds;
    test_hold_stall;
    test_reset_mid_issue;
    test_back_to_back;
    test_counter_wrap;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
